lower_part_or_ripple_carry_adder_16: RTL and testbench

Registered 16-bit approximate adder of the lower-part-OR (LOA) type, for error-tolerant datapaths (image/DSP accumulation) in the approximate arithmetic block library. The low LOWER_WIDTH bits are approximated by bitwise OR. The upper bits are summed exactly by a ripple-carry chain, with a carry predicted from the top lower-part bit pair. The 17-bit result is registered once.

---
 rtl/lower_part_or_ripple_carry_adder_16.sv | 71 +++++++
 tb/tb_lower_part_or_ripple_carry_adder_16.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lower_part_or_ripple_carry_adder_16.sv
// lower_part_or_ripple_carry_adder_16
//
// Registered 16-bit approximate adder of the lower-part-OR type.
// The low LOWER_WIDTH bits are approximated with a bitwise OR. The upper
// bits use an exact ripple-carry chain. The carry into that chain is
// predicted from the top bit pair of the lower part. The 17-bit result is
// registered once, so the latency is one clock.
//
// Parameters
//   LOWER_WIDTH : number of approximated low bits, 1..15 (default 8)
//
// Ports
//   clk_i    : clock; the result register updates on the rising edge
//   rst_ni   : asynchronous active-low reset; clears result_o
//   add1_i   : operand A, 16-bit unsigned
//   add2_i   : operand B, 16-bit unsigned
//   result_o : registered approximate sum; bit 16 is the carry-out
module lower_part_or_ripple_carry_adder_16 #(
    parameter int unsigned LOWER_WIDTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] add1_i,
    input  logic [15:0] add2_i,
    output logic [16:0] result_o
);

    localparam int unsigned L = LOWER_WIDTH;

    generate
        if (L < 1 || L > 15) begin : g_bad_lower_width
            $error("LOWER_WIDTH must be in the range 1..15");
        end
    endgenerate

    logic [16:0] w_sum;
    logic [16:0] r_result;

    always_comb begin
        logic v_carry;
        w_sum   = '0;
        v_carry = 1'b0;

        // The lower part never generates a carry.
        for (int unsigned i = 0; i < L; i++) begin
            w_sum[i] = add1_i[i] | add2_i[i];
        end

        // Predict the carry into the upper part from the top lower-part bits.
        v_carry = add1_i[L-1] & add2_i[L-1];

        // Exact ripple-carry chain over the upper bits.
        for (int unsigned i = L; i < 16; i++) begin
            w_sum[i] = add1_i[i] ^ add2_i[i] ^ v_carry;
            v_carry  = (add1_i[i] & add2_i[i]) | (v_carry & (add1_i[i] ^ add2_i[i]));
        end

        w_sum[16] = v_carry;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
        end else begin
            r_result <= w_sum;
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_lower_part_or_ripple_carry_adder_16.sv
module tb_lower_part_or_ripple_carry_adder_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] res1;
    logic [16:0] res4;
    logic [16:0] res8;
    logic [16:0] res15;

    int checks = 0;
    int errors = 0;

    lower_part_or_ripple_carry_adder_16 #(.LOWER_WIDTH(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .add1_i(a), .add2_i(b), .result_o(res8)
    );
    lower_part_or_ripple_carry_adder_16 #(.LOWER_WIDTH(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .add1_i(a), .add2_i(b), .result_o(res1)
    );
    lower_part_or_ripple_carry_adder_16 #(.LOWER_WIDTH(4)) u_l4 (
        .clk_i(clk), .rst_ni(rst_n), .add1_i(a), .add2_i(b), .result_o(res4)
    );
    lower_part_or_ripple_carry_adder_16 #(.LOWER_WIDTH(15)) u_l15 (
        .clk_i(clk), .rst_ni(rst_n), .add1_i(a), .add2_i(b), .result_o(res15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: OR of the low fields plus the exact sum of the high fields
    // (with the predicted carry) placed back at weight 2^L.
    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input int unsigned lw);
        int unsigned xi, yi, mask, lo, hi, c;
        xi   = x;
        yi   = y;
        mask = (32'd1 << lw) - 1;
        lo   = (xi & mask) | (yi & mask);
        c    = ((xi >> (lw - 1)) & (yi >> (lw - 1))) & 32'd1;
        hi   = (xi >> lw) + (yi >> lw) + c;
        return 17'(lo + (hi << lw));
    endfunction

    // Apply operands just after an edge, then sample just after the next edge.
    task automatic apply(input logic [15:0] x, input logic [15:0] y);
        a = x;
        b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a = 16'hFFFF;
        b = 16'hFFFF;
        #3;
        checks++;
        if (res8 !== 17'h00000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", res8, 17'h00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (res8 !== 17'h1FFFF) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", res8, 17'h1FFFF);
        end
        // Assert reset between edges: must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res8 !== 17'h00000) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", res8, 17'h00000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (res8 !== 17'h00000) begin
            errors++;
            $display("FAIL reset_held_edge: got %h expected %h", res8, 17'h00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors;
        logic [15:0] va [7] = '{16'h29AF, 16'hFADC, 16'h8943, 16'h8051,
                                16'h5555, 16'hABCD, 16'h0000};
        logic [15:0] vb [7] = '{16'h7A1B, 16'h00DC, 16'hFFFF, 16'h8086,
                                16'hAAAA, 16'h0000, 16'h0001};
        logic [16:0] ve [7] = '{17'h0A3BF, 17'h0FBDC, 17'h188FF, 17'h100D7,
                                17'h0FFFF, 17'h0ABCD, 17'h00001};
        for (int i = 0; i < 7; i++) begin
            apply(va[i], vb[i]);
            checks++;
            if (res8 !== ve[i]) begin
                errors++;
                $display("FAIL vector_%0d %h+%h: got %h expected %h",
                         i, va[i], vb[i], res8, ve[i]);
            end
        end
    endtask

    task automatic test_input_between_edges;
        apply(16'h1234, 16'h0101);
        a = 16'hFFFF;
        b = 16'hFFFF;
        #3;
        checks++;
        if (res8 !== 17'h01335) begin
            errors++;
            $display("FAIL between_edges: got %h expected %h", res8, 17'h01335);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] va [3] = '{16'h29AF, 16'h1100, 16'h8116};
        logic [15:0] vb [3] = '{16'h7A1B, 16'h1111, 16'h1CCE};
        logic [16:0] ve [3] = '{17'h0A3BF, 17'h02211, 17'h09DDE};
        for (int i = 0; i < 3; i++) begin
            apply(va[i], vb[i]);
            checks++;
            if (res8 !== ve[i]) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h expected %h", i, res8, ve[i]);
            end
        end
    endtask

    task automatic test_midstream_reset;
        apply(16'h4321, 16'h1111);
        a = 16'hFFFF;
        b = 16'h0001;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res8 !== 17'h00000) begin
            errors++;
            $display("FAIL midstream_reset: got %h expected %h", res8, 17'h00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (res8 !== model(16'hFFFF, 16'h0001, 8)) begin
            errors++;
            $display("FAIL after_midstream_reset: got %h expected %h",
                     res8, model(16'hFFFF, 16'h0001, 8));
        end
    endtask

    task automatic test_sweep;
        int unsigned lws [4] = '{1, 4, 8, 15};
        logic [16:0] got [4];
        logic [16:0] exp_v;
        int unsigned exact, r;
        logic [15:0] x, y;
        for (int n = 0; n < 300; n++) begin
            if (n == 0) begin
                x = 16'hFFFF; y = 16'hFFFF;
            end else if (n == 1) begin
                x = 16'h0000; y = 16'h0000;
            end else begin
                x = 16'($urandom);
                y = 16'($urandom);
            end
            apply(x, y);
            got = '{res1, res4, res8, res15};
            exact = 32'(x) + 32'(y);
            for (int k = 0; k < 4; k++) begin
                exp_v = model(x, y, lws[k]);
                checks++;
                if (got[k] !== exp_v) begin
                    errors++;
                    $display("FAIL sweep_L%0d %h+%h: got %h expected %h",
                             lws[k], x, y, got[k], exp_v);
                end
                // A predicted carry can overshoot the exact sum by up to 2^(L-1).
                r = 32'(got[k]);
                checks++;
                if (r + ((32'd1 << lws[k]) - 1) < exact ||
                    r > exact + (32'd1 << (lws[k] - 1))) begin
                    errors++;
                    $display("FAIL sweep_bound_L%0d %h+%h: got %h exact %h",
                             lws[k], x, y, got[k], exact);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_input_between_edges();
        test_back_to_back();
        test_midstream_reset();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
